// File: rtl/qif_spike_rate_decoder.sv
// qif_spike_rate_decoder
// Detects spikes on the QIF membrane voltage with a hysteretic threshold,
// counts them over a fixed window of clock cycles and offers the resulting
// saturating 8-bit rate code over a valid/ready handshake.

module qif_spike_rate_decoder #(
    parameter logic [23:0] WINDOW  = 24'd1_000_000,
    parameter logic [7:0]  V_TH    = 8'd200,
    parameter logic [7:0]  V_REARM = 8'd100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] v_mem,
    output logic       spike_pulse,
    output logic [7:0] rate,
    output logic       rate_valid,
    input  logic       rate_ready,
    output logic       overrun
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned WIN_W = 24;
    localparam logic [CNT_W-1:0] CNT_MAX  = 8'hFF;
    localparam logic [WIN_W-1:0] WIN_LAST = WINDOW - 24'd1;

    typedef enum logic {
        ARMED = 1'b0,
        FIRED = 1'b1
    } det_state_t;

    det_state_t       state;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] spike_cnt;

    logic             det_c;
    logic             win_last_c;
    logic             xfer_c;
    logic [CNT_W-1:0] cnt_next_c;

    // Spike event, window close, handshake transfer and saturating count update
    always_comb begin
        det_c      = en && (state == ARMED) && (v_mem >= V_TH);
        win_last_c = en && (win_cnt == WIN_LAST);
        xfer_c     = rate_valid && rate_ready;
        cnt_next_c = (spike_cnt == CNT_MAX) ? CNT_MAX : spike_cnt + CNT_W'(det_c);
    end

    // Hysteretic detector: one pulse per excursion above V_TH, re-arm below V_REARM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARMED;
            spike_pulse <= 1'b0;
        end else if (!en) begin
            state       <= ARMED;
            spike_pulse <= 1'b0;
        end else begin
            spike_pulse <= 1'b0;
            case (state)
                ARMED: begin
                    if (v_mem >= V_TH) begin
                        state       <= FIRED;
                        spike_pulse <= 1'b1;
                    end
                end
                FIRED: begin
                    if (v_mem < V_REARM) begin
                        state <= ARMED;
                    end
                end
                default: state <= ARMED;
            endcase
        end
    end

    // Window and spike counters; a spike on the terminal edge closes with its window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt   <= '0;
            spike_cnt <= '0;
        end else if (!en) begin
            win_cnt   <= '0;
            spike_cnt <= '0;
        end else if (win_last_c) begin
            win_cnt   <= '0;
            spike_cnt <= '0;
        end else begin
            win_cnt   <= win_cnt + 24'd1;
            spike_cnt <= cnt_next_c;
        end
    end

    // Rate publication: load on close, drop valid on transfer, flag overwrite of unread rate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate       <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (win_last_c) begin
            rate       <= cnt_next_c;
            rate_valid <= 1'b1;
            if (rate_valid && !rate_ready) begin
                overrun <= 1'b1;
            end
        end else if (xfer_c) begin
            rate_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qif_spike_rate_decoder.sv
// Directed bench for qif_spike_rate_decoder: a WINDOW=100 instance for the
// main behaviour and a WINDOW=2000 instance for count saturation.

module tb_qif_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] v_mem;
    logic       rate_ready;
    logic       spike_pulse;
    logic [7:0] rate;
    logic       rate_valid;
    logic       overrun;

    logic       en2;
    logic [7:0] v_mem2;
    logic       rate_ready2;
    logic       spike_pulse2;
    logic [7:0] rate2;
    logic       rate_valid2;
    logic       overrun2;

    int n_cmp = 0;
    int n_err = 0;
    int wc    = 0;
    int pulses;

    always #5 clk = ~clk;

    qif_spike_rate_decoder #(
        .WINDOW (24'd100),
        .V_TH   (8'd200),
        .V_REARM(8'd100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .v_mem      (v_mem),
        .spike_pulse(spike_pulse),
        .rate       (rate),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .overrun    (overrun)
    );

    qif_spike_rate_decoder #(
        .WINDOW (24'd2000),
        .V_TH   (8'd200),
        .V_REARM(8'd100)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .en         (en2),
        .v_mem      (v_mem2),
        .spike_pulse(spike_pulse2),
        .rate       (rate2),
        .rate_valid (rate_valid2),
        .rate_ready (rate_ready2),
        .overrun    (overrun2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle; wc tracks edges into the current window
    task automatic tick();
        @(posedge clk);
        #1;
        wc++;
    endtask

    // n excursions 210 -> 50 on the main instance, checking the pulse pattern
    task automatic spikes(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            v_mem = 8'd210;
            tick();
            chk({tag, "_pulse_hi"}, 32'(spike_pulse), 32'd1);
            v_mem = 8'd50;
            tick();
            chk({tag, "_pulse_lo"}, 32'(spike_pulse), 32'd0);
        end
    endtask

    // Idle with v_mem=0 until the window has seen 'target' edges
    task automatic fill_until(input int target);
        v_mem  = 8'd0;
        v_mem2 = 8'd0;
        while (wc < target) tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; v_mem = 8'd0; rate_ready = 1'b0;
        en2 = 1'b0; v_mem2 = 8'd0; rate_ready2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pulse", 32'(spike_pulse), 32'd0);
        chk("rst_rate", 32'(rate), 32'd0);
        chk("rst_valid", 32'(rate_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Window 1: seven clean spikes -> rate 7 exactly at edge 100
        rst = 1'b0; en = 1'b1; wc = 0;
        spikes(7, "w1");
        fill_until(99);
        chk("w1_valid_e99", 32'(rate_valid), 32'd0);
        tick();
        chk("w1_valid", 32'(rate_valid), 32'd1);
        chk("w1_rate", 32'(rate), 32'd7);

        // Window 2: consume, hysteresis, then a crossing on the terminal edge
        wc = 0;
        rate_ready = 1'b1;
        tick();
        rate_ready = 1'b0;
        chk("xfer_valid", 32'(rate_valid), 32'd0);
        chk("xfer_rate_hold", 32'(rate), 32'd7);
        v_mem = 8'd210; tick(); chk("hys_first", 32'(spike_pulse), 32'd1);
        v_mem = 8'd150; tick(); chk("hys_mid", 32'(spike_pulse), 32'd0);
        v_mem = 8'd210; tick(); chk("hys_no_rearm", 32'(spike_pulse), 32'd0);
        v_mem = 8'd50;  tick(); chk("hys_rearm", 32'(spike_pulse), 32'd0);
        v_mem = 8'd200; tick(); chk("th_equal", 32'(spike_pulse), 32'd1);
        v_mem = 8'd50;  tick();
        fill_until(99);
        chk("w2_valid_e99", 32'(rate_valid), 32'd0);
        v_mem = 8'd210;
        tick();
        chk("term_pulse", 32'(spike_pulse), 32'd1);
        chk("term_rate", 32'(rate), 32'd3);
        chk("term_valid", 32'(rate_valid), 32'd1);

        // Window 3: starts empty; ready asserted only on the closing edge
        wc = 0;
        v_mem = 8'd50; tick();
        chk("w3_rearm", 32'(spike_pulse), 32'd0);
        spikes(4, "w3");
        fill_until(99);
        chk("w3_rate_stable", 32'(rate), 32'd3);
        chk("w3_valid_pend", 32'(rate_valid), 32'd1);
        rate_ready = 1'b1;
        tick();
        rate_ready = 1'b0;
        chk("rdy_close_rate", 32'(rate), 32'd4);
        chk("rdy_close_valid", 32'(rate_valid), 32'd1);
        chk("rdy_close_ovr", 32'(overrun), 32'd0);

        // Window 4: unconsumed rate overwritten on close -> overrun
        wc = 0;
        spikes(2, "w4");
        fill_until(99);
        chk("w4_ovr_pre", 32'(overrun), 32'd0);
        tick();
        chk("ovr_rate", 32'(rate), 32'd2);
        chk("ovr_valid", 32'(rate_valid), 32'd1);
        chk("ovr_flag", 32'(overrun), 32'd1);

        // Window 5: partial count, then en=0 for 37 cycles with a consume inside
        wc = 0;
        spikes(3, "w5");
        en = 1'b0; v_mem = 8'd210; pulses = 0;
        for (int i = 0; i < 37; i++) begin
            rate_ready = (i == 10);
            tick();
            if (spike_pulse) pulses++;
            if (i == 10) begin
                chk("dis_xfer_valid", 32'(rate_valid), 32'd0);
                chk("dis_xfer_rate", 32'(rate), 32'd2);
            end
        end
        rate_ready = 1'b0;
        chk("dis_pulses", 32'(pulses), 32'd0);
        chk("dis_ovr_sticky", 32'(overrun), 32'd1);

        // Fresh window after en rises: one spike only
        en = 1'b1; v_mem = 8'd0; wc = 0;
        spikes(1, "w6");
        fill_until(99);
        chk("w6_valid_e99", 32'(rate_valid), 32'd0);
        tick();
        chk("w6_rate", 32'(rate), 32'd1);
        chk("w6_valid", 32'(rate_valid), 32'd1);

        // Async reset mid-window clears outputs before the next edge
        wc = 0;
        v_mem = 8'd210; tick();
        chk("pre_rst_pulse", 32'(spike_pulse), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_pulse", 32'(spike_pulse), 32'd0);
        chk("arst_rate", 32'(rate), 32'd0);
        chk("arst_valid", 32'(rate_valid), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        v_mem = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; wc = 0;
        fill_until(99);
        chk("post_rst_e99", 32'(rate_valid), 32'd0);
        tick();
        chk("post_rst_valid", 32'(rate_valid), 32'd1);
        chk("post_rst_rate", 32'(rate), 32'd0);

        // Saturation: 300 spikes in a 2000-cycle window -> 255
        en = 1'b0; en2 = 1'b1; wc = 0;
        for (int i = 0; i < 300; i++) begin
            v_mem2 = 8'd210; tick();
            v_mem2 = 8'd50;  tick();
        end
        fill_until(1999);
        chk("sat_valid_pre", 32'(rate_valid2), 32'd0);
        tick();
        chk("sat_rate", 32'(rate2), 32'd255);
        chk("sat_valid", 32'(rate_valid2), 32'd1);
        chk("sat_ovr", 32'(overrun2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
